instruction_fetch_stage: RTL and testbench

Fetch stage between the program-counter stage and the decoding stage of the RISC-V pipeline. It takes the current PC and issues a single-outstanding request to instruction memory over a valid/ready handshake. It captures the returned instruction into the IF/ID register, holds it while decode is stalled, and discards in-flight fetches when the pipeline is cleared on a mispredict or jump. It also tells the PC stage when it may advance.

---
 rtl/riscv_pipeline_pkg.sv | 18 +
 rtl/if_id_register.sv | 42 ++++
 rtl/instruction_fetch_stage.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipeline_pkg.sv
// Shared definitions for the RISC-V pipeline stages: widths, the canonical NOP
// and the fetch-stage state encoding.
package riscv_pipeline_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: clear beats stall, stall beats load, and anything
// else becomes a NOP bubble with the PC left where it was.
module if_id_register
    import riscv_pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP = NOP_INSTRUCTION
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  stall,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic [DATA_WIDTH-1:0] load_instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            instruction <= NOP;
            valid       <= 1'b0;
        end else if (clear) begin
            instruction <= NOP;
            valid       <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                pc          <= load_pc;
                instruction <= load_instruction;
                valid       <= 1'b1;
            end else begin
                instruction <= NOP;
                valid       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: single-outstanding instruction-memory requests, a one-entry hold
// buffer for decode stalls, and discard of in-flight fetches on pipeline clear.
module instruction_fetch_stage
    import riscv_pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP = NOP_INSTRUCTION
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  CLEAR_DECODING_STAGE,
    input  logic                  STALL_DECODING_STAGE,
    output logic                  STALL_PROGRAM_COUNTER,
    output logic                  IMEM_REQ_VALID,
    input  logic                  IMEM_REQ_READY,
    output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
    input  logic                  IMEM_RESP_VALID,
    input  logic [DATA_WIDTH-1:0] IMEM_RESP_DATA,
    output logic [ADDR_WIDTH-1:0] PC_DECODING,
    output logic [DATA_WIDTH-1:0] INSTRUCTION_DECODING,
    output logic                  VALID_DECODING
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_data;

    logic                  accept;
    logic                  resp_kept;
    logic                  load;
    logic [ADDR_WIDTH-1:0] load_pc;
    logic [DATA_WIDTH-1:0] load_instruction;

    // The PC stage may only advance on the edge where memory takes the request.
    assign IMEM_ADDR             = PC;
    assign IMEM_REQ_VALID        = (state == FETCH_REQ) && !CLEAR_DECODING_STAGE;
    assign accept                = IMEM_REQ_VALID && IMEM_REQ_READY;
    assign STALL_PROGRAM_COUNTER = !accept;

    assign resp_kept = (state == FETCH_WAIT) && IMEM_RESP_VALID && !drop && !CLEAR_DECODING_STAGE;

    always_comb begin
        state_next       = state;
        load             = 1'b0;
        load_pc          = fetch_pc;
        load_instruction = IMEM_RESP_DATA;
        unique case (state)
            FETCH_IDLE: state_next = FETCH_REQ;
            FETCH_REQ: begin
                if (accept) begin
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (IMEM_RESP_VALID) begin
                    if (!resp_kept) begin
                        state_next = FETCH_REQ;
                    end else if (!STALL_DECODING_STAGE) begin
                        load       = 1'b1;
                        state_next = FETCH_REQ;
                    end else begin
                        state_next = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (CLEAR_DECODING_STAGE) begin
                    state_next = FETCH_REQ;
                end else if (!STALL_DECODING_STAGE) begin
                    load             = 1'b1;
                    load_pc          = hold_pc;
                    load_instruction = hold_data;
                    state_next       = FETCH_REQ;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A clear while waiting marks the outstanding fetch stale so its late response is discarded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= '0;
            drop     <= 1'b0;
        end else if (accept) begin
            fetch_pc <= PC;
            drop     <= 1'b0;
        end else if (state == FETCH_WAIT && !IMEM_RESP_VALID && CLEAR_DECODING_STAGE) begin
            drop <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_pc   <= '0;
            hold_data <= NOP;
        end else if (resp_kept && STALL_DECODING_STAGE) begin
            hold_pc   <= fetch_pc;
            hold_data <= IMEM_RESP_DATA;
        end
    end

    if_id_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NOP        (NOP)
    ) u_if_id (
        .clk              (CLK),
        .rst              (RST),
        .clear            (CLEAR_DECODING_STAGE),
        .stall            (STALL_DECODING_STAGE),
        .load             (load),
        .load_pc          (load_pc),
        .load_instruction (load_instruction),
        .pc               (PC_DECODING),
        .instruction      (INSTRUCTION_DECODING),
        .valid            (VALID_DECODING)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: a PC-stage and memory model feed a scoreboard
// of fetches that decode must receive, plus a directed timing walk-through.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        clear;
    logic        stall;
    logic        stall_pc;
    logic        req_valid;
    logic        ready;
    logic [31:0] imem_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] pc_dec;
    logic [31:0] instr_dec;
    logic        valid_dec;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .CLK                   (clk),
        .RST                   (rst),
        .PC                    (pc_in),
        .CLEAR_DECODING_STAGE  (clear),
        .STALL_DECODING_STAGE  (stall),
        .STALL_PROGRAM_COUNTER (stall_pc),
        .IMEM_REQ_VALID        (req_valid),
        .IMEM_REQ_READY        (ready),
        .IMEM_ADDR             (imem_addr),
        .IMEM_RESP_VALID       (resp_valid),
        .IMEM_RESP_DATA        (resp_data),
        .PC_DECODING           (pc_dec),
        .INSTRUCTION_DECODING  (instr_dec),
        .VALID_DECODING        (valid_dec)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    // Each entry is {pc, instruction} that decode is still owed.
    logic [63:0] exp_q[$];

    logic [31:0] pc_model;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          next_lat;

    logic snap_rst;
    logic snap_accept;
    logic snap_clear;
    logic snap_stall_pc;
    logic mon_prev_pending;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h0000_0008) begin
            return 32'h00A0_0093;
        end
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: advance the PC-stage and memory models from the last sample, then drive inputs.
    task automatic apply_stimulus(input logic r, input logic s, input logic c, input logic rs,
                                  input logic [31:0] redir, input int lat);
        @(negedge clk);
        if (snap_rst) begin
            pc_model = 32'h0;
        end else begin
            if (snap_accept) begin
                exp_q.push_back({pc_model, mem_data(pc_model)});
                mem_cnt  = next_lat;
                mem_addr = pc_model;
            end
            if (snap_clear) begin
                pc_model = redirect_pc;
            end else if (!snap_stall_pc) begin
                pc_model = pc_model + 32'd4;
            end
        end
        resp_valid = 1'b0;
        resp_data  = $urandom();
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                resp_valid = 1'b1;
                resp_data  = mem_data(mem_addr);
            end
        end
        next_lat = lat;
        ready    = r;
        stall    = s;
        clear    = c;
        rst      = rs;
        if (c) begin
            redirect_pc = redir;
        end
        pc_in = pc_model;
    endtask

    task automatic step_check(input int cyc, input logic r, input logic s, input logic c, input logic rs,
                              input logic [31:0] redir, input int lat,
                              input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                              input logic ereq, input logic [31:0] eaddr, input logic estall);
        apply_stimulus(r, s, c, rs, redir, lat);
        #3;
        check_output($sformatf("c%0d_valid_decoding", cyc), valid_dec, ev);
        check_output($sformatf("c%0d_pc_decoding", cyc), pc_dec, epc);
        check_output($sformatf("c%0d_instruction_decoding", cyc), instr_dec, einst);
        check_output($sformatf("c%0d_req_valid", cyc), req_valid, ereq);
        check_output($sformatf("c%0d_imem_addr", cyc), imem_addr, eaddr);
        check_output($sformatf("c%0d_stall_pc", cyc), stall_pc, estall);
    endtask

    // Monitor: records what happened this cycle and settles the scoreboard against decode.
    initial begin
        logic [63:0] e;
        mon_prev_pending = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            snap_rst      = rst;
            snap_accept   = !rst && req_valid && ready;
            snap_clear    = !rst && clear;
            snap_stall_pc = stall_pc;
            if (rst) begin
                exp_q.delete();
                mon_prev_pending = 1'b0;
            end else begin
                check_output("addr_follows_pc", imem_addr, pc_in);
                check_output("stall_pc_vs_handshake", stall_pc, !(req_valid && ready));
                if (clear) check_output("req_gated_by_clear", req_valid, 1'b0);
                if (mon_prev_pending && !clear) check_output("req_sticky", req_valid, 1'b1);
                if (mem_cnt > 0 || resp_valid) check_output("single_outstanding", req_valid, 1'b0);
                if (!valid_dec) check_output("bubble_is_nop", instr_dec, NOP_WORD);
                if (clear) begin
                    exp_q.delete();
                end else if (valid_dec && !stall) begin
                    n_compared++;
                    if (exp_q.size() == 0) begin
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_instr: got pc %h instr %h, expected none", pc_dec, instr_dec);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pc_dec, instr_dec} !== e) begin
                            n_mismatched++;
                            $display("[TB] FAIL delivered_instr: got pc %h instr %h, expected pc %h instr %h",
                                     pc_dec, instr_dec, e[63:32], e[31:0]);
                        end
                    end
                end
                mon_prev_pending = req_valid && !ready;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d0;
        logic [31:0] d4;
        logic [31:0] d200;
        d0   = mem_data(32'h0);
        d4   = mem_data(32'h4);
        d200 = mem_data(32'h200);

        pc_model      = 32'h0;
        redirect_pc   = 32'h0;
        mem_addr      = 32'h0;
        mem_cnt       = 0;
        next_lat      = 1;
        snap_rst      = 1'b1;
        snap_accept   = 1'b0;
        snap_clear    = 1'b0;
        snap_stall_pc = 1'b1;
        rst           = 1'b1;
        ready         = 1'b0;
        stall         = 1'b0;
        clear         = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = 32'h0;
        pc_in         = 32'h0;

        $display("[TB] reset and directed sequence");
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1);
        #3;
        check_output("reset_req_valid", req_valid, 1'b0);
        check_output("reset_stall_pc", stall_pc, 1'b1);
        check_output("reset_pc_decoding", pc_dec, 32'h0);
        check_output("reset_instruction", instr_dec, NOP_WORD);
        check_output("reset_valid", valid_dec, 1'b0);

        //          cyc  r  s  c  rs  redir        lat  ev  epc         einst         req addr         stall
        step_check(0,   1, 0, 0, 0, 32'h0,       1,   0, 32'h0,      NOP_WORD,     0, 32'h0,       1);
        step_check(1,   1, 0, 0, 0, 32'h0,       1,   0, 32'h0,      NOP_WORD,     1, 32'h0,       0);
        step_check(2,   1, 0, 0, 0, 32'h0,       1,   0, 32'h0,      NOP_WORD,     0, 32'h4,       1);
        step_check(3,   1, 0, 0, 0, 32'h0,       1,   1, 32'h0,      d0,           1, 32'h4,       0);
        step_check(4,   1, 0, 0, 0, 32'h0,       1,   0, 32'h0,      NOP_WORD,     0, 32'h8,       1);
        step_check(5,   1, 0, 0, 0, 32'h0,       1,   1, 32'h4,      d4,           1, 32'h8,       0);
        step_check(6,   1, 1, 0, 0, 32'h0,       1,   0, 32'h4,      NOP_WORD,     0, 32'hC,       1);
        step_check(7,   1, 1, 0, 0, 32'h0,       1,   0, 32'h4,      NOP_WORD,     0, 32'hC,       1);
        step_check(8,   1, 1, 0, 0, 32'h0,       1,   0, 32'h4,      NOP_WORD,     0, 32'hC,       1);
        step_check(9,   1, 0, 0, 0, 32'h0,       1,   0, 32'h4,      NOP_WORD,     0, 32'hC,       1);
        step_check(10,  1, 0, 0, 0, 32'h0,       3,   1, 32'h8,      32'h00A00093, 1, 32'hC,       0);
        step_check(11,  1, 0, 1, 0, 32'h200,     1,   0, 32'h8,      NOP_WORD,     0, 32'h10,      1);
        step_check(12,  1, 0, 0, 0, 32'h0,       1,   0, 32'h8,      NOP_WORD,     0, 32'h200,     1);
        step_check(13,  1, 0, 0, 0, 32'h0,       1,   0, 32'h8,      NOP_WORD,     0, 32'h200,     1);
        step_check(14,  1, 0, 0, 0, 32'h0,       1,   0, 32'h8,      NOP_WORD,     1, 32'h200,     0);
        step_check(15,  1, 0, 0, 0, 32'h0,       1,   0, 32'h8,      NOP_WORD,     0, 32'h204,     1);
        step_check(16,  1, 1, 1, 0, 32'h100,     1,   1, 32'h200,    d200,         0, 32'h204,     1);
        step_check(17,  0, 0, 0, 0, 32'h0,       1,   0, 32'h200,    NOP_WORD,     1, 32'h100,     1);
        step_check(18,  0, 0, 0, 0, 32'h0,       1,   0, 32'h200,    NOP_WORD,     1, 32'h100,     1);
        step_check(19,  0, 0, 0, 0, 32'h0,       1,   0, 32'h200,    NOP_WORD,     1, 32'h100,     1);
        step_check(20,  1, 0, 0, 0, 32'h0,       2,   0, 32'h200,    NOP_WORD,     1, 32'h100,     0);
        step_check(21,  1, 0, 0, 1, 32'h0,       1,   0, 32'h200,    NOP_WORD,     0, 32'h104,     1);
        step_check(22,  1, 0, 0, 1, 32'h0,       1,   0, 32'h0,      NOP_WORD,     0, 32'h0,       1);
        step_check(23,  1, 0, 0, 0, 32'h0,       1,   0, 32'h0,      NOP_WORD,     0, 32'h0,       1);
        step_check(24,  1, 0, 0, 0, 32'h0,       1,   0, 32'h0,      NOP_WORD,     1, 32'h0,       0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom % 100) < 65, ($urandom % 100) < 25, ($urandom % 100) < 6, 1'b0,
                           $urandom & 32'h0000_3FFC, int'($urandom_range(1, 3)));
        end

        // Stop new requests and let everything already accepted reach decode.
        repeat (30) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        check_output("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
